// File: rtl/stoch_pkg.sv
// Shared helpers for the stochastic-bitstream decode stages: window sizing,
// result sizing and the signed per-sample delta.
package stoch_pkg;

    localparam int DEFAULT_COUNTER_SIZE = 8;

    // Number of enabled samples in one decode window.
    function automatic int window_len(input int counter_size);
        return 1 << counter_size;
    endfunction

    // Narrowest signed result that holds [-2^cs, +2^cs] without overflow.
    function automatic int min_out_width(input int counter_size);
        return counter_size + 2;
    endfunction

    // One signed sample: +1, -1, or 0 when both or neither channel fires.
    function automatic logic signed [1:0] sample_delta(input logic a_p, input logic a_m);
        case ({a_p, a_m})
            2'b10:   return 2'sb01;
            2'b01:   return 2'sb11;
            default: return 2'sb00;
        endcase
    endfunction

endpackage

// File: rtl/stoch_window_counter.sv
// Enabled-sample counter for one decode window; wrap strobes combinationally
// on the edge that consumes the last sample of the window.
module stoch_window_counter
    import stoch_pkg::*;
#(
    parameter int COUNTER_SIZE = DEFAULT_COUNTER_SIZE
) (
    input  logic CLK,
    input  logic nRST,
    input  logic en,
    input  logic clr,
    output logic wrap
);

    localparam logic [COUNTER_SIZE-1:0] LAST = COUNTER_SIZE'(window_len(COUNTER_SIZE) - 1);

    logic [COUNTER_SIZE-1:0] count;

    // clr wins over a coincident final sample, so no strobe is raised then.
    assign wrap = en & ~clr & (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/stoch_signed_decode.sv
// Signed stochastic bitstream decoder: sums (a_p - a_m) over windows of
// 2^COUNTER_SIZE enabled samples. Define STOCH_DECODE_OVF_EN for the ovf flag.
module stoch_signed_decode
    import stoch_pkg::*;
#(
    parameter int COUNTER_SIZE = DEFAULT_COUNTER_SIZE,
    parameter int OUT_WIDTH    = min_out_width(COUNTER_SIZE)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 a_p,
    input  logic                 a_m,
    output logic [OUT_WIDTH-1:0] y,
    output logic                 y_valid,
    input  logic                 y_ready
`ifdef STOCH_DECODE_OVF_EN
    ,
    output logic                 ovf
`endif
);

    logic                        wrap;
    logic signed [1:0]           d;
    logic signed [OUT_WIDTH-1:0] delta;
    logic signed [OUT_WIDTH-1:0] acc;
    logic signed [OUT_WIDTH-1:0] sum;

    stoch_window_counter #(
        .COUNTER_SIZE(COUNTER_SIZE)
    ) u_window_counter (
        .CLK (CLK),
        .nRST(nRST),
        .en  (en),
        .clr (clr),
        .wrap(wrap)
    );

    // NOTE: every combinational output gets a value on every path, so no
    // latch is inferred.
    always_comb begin
        d     = sample_delta(a_p, a_m);
        delta = {{(OUT_WIDTH-2){d[1]}}, d};
        sum   = acc + delta;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= wrap ? '0 : sum;
        end
    end

    // A completing window always loads, even over an unconsumed result.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            y       <= '0;
            y_valid <= 1'b0;
        end else if (wrap) begin
            y       <= sum;
            y_valid <= 1'b1;
        end else if (y_ready) begin
            y_valid <= 1'b0;
        end
    end

`ifdef STOCH_DECODE_OVF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ovf <= 1'b0;
        end else if (wrap && y_valid && !y_ready) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_stoch_signed_decode.sv
// Self-checking bench for stoch_signed_decode at COUNTER_SIZE=4: directed
// window scenarios followed by random traffic against a sample-sum model.
module tb_stoch_signed_decode;

    localparam int CS  = 4;
    localparam int OW  = CS + 2;
    localparam int WIN = 1 << CS;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          en = 1'b0;
    logic          clr = 1'b0;
    logic          a_p = 1'b0;
    logic          a_m = 1'b0;
    logic          y_ready = 1'b0;
    logic [OW-1:0] y;
    logic          y_valid;
`ifdef STOCH_DECODE_OVF_EN
    logic          ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: running sum and count of enabled samples in the window.
    int win_sum   = 0;
    int win_count = 0;
    int exp_y     = 0;
    bit exp_valid = 0;
    bit exp_ovf   = 0;

    stoch_signed_decode #(
        .COUNTER_SIZE(CS),
        .OUT_WIDTH   (OW)
    ) dut (
        .CLK    (CLK),
        .nRST   (nRST),
        .en     (en),
        .clr    (clr),
        .a_p    (a_p),
        .a_m    (a_m),
        .y      (y),
        .y_valid(y_valid),
        .y_ready(y_ready)
`ifdef STOCH_DECODE_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag);
        int y_int;
        y_int = int'($signed(y));
        n_checks++;
        assert (y_valid === exp_valid) else begin
            n_fail++;
            $error("FAIL %s y_valid: observed %0b expected %0b", tag, y_valid, exp_valid);
        end
        n_checks++;
        assert (y_int === exp_y) else begin
            n_fail++;
            $error("FAIL %s y: observed %0d expected %0d", tag, y_int, exp_y);
        end
`ifdef STOCH_DECODE_OVF_EN
        n_checks++;
        assert (ovf === exp_ovf) else begin
            n_fail++;
            $error("FAIL %s ovf: observed %0b expected %0b", tag, ovf, exp_ovf);
        end
`endif
    endtask

    task automatic model_edge(input bit e, input bit p, input bit m, input bit c, input bit r);
        bit done;
        done = 0;
        if (c) begin
            win_sum   = 0;
            win_count = 0;
        end else if (e) begin
            win_sum   += int'(p) - int'(m);
            win_count += 1;
            if (win_count == WIN) done = 1;
        end
        if (done) begin
            if (exp_valid && !r) exp_ovf = 1;
            exp_y     = win_sum;
            exp_valid = 1;
            win_sum   = 0;
            win_count = 0;
        end else if (exp_valid && r) begin
            exp_valid = 0;
        end
    endtask

    // Drive inputs at the falling edge, update the model at the rising edge,
    // and compare shortly after it.
    task automatic cycle(input bit e, input bit p, input bit m, input bit c, input bit r,
                         input string tag);
        @(negedge CLK);
        en = e; a_p = p; a_m = m; clr = c; y_ready = r;
        @(posedge CLK);
        model_edge(e, p, m, c, r);
        #1;
        check(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK);
        #2;
        nRST = 1'b0;
        #1;
        win_sum = 0; win_count = 0; exp_y = 0; exp_valid = 0; exp_ovf = 0;
        check(tag);
        @(negedge CLK);
        en = 0; clr = 0; a_p = 0; a_m = 0; y_ready = 0;
        nRST = 1'b1;
    endtask

    initial begin
        do_reset("reset");

        for (int i = 0; i < WIN; i++) cycle(1, 1, 0, 0, 0, "win_plus");
        cycle(0, 0, 0, 0, 1, "consume_plus");

        for (int i = 0; i < WIN; i++) cycle(1, 0, 1, 0, 1, "win_minus");
        cycle(0, 0, 0, 0, 1, "consume_minus");

        for (int i = 0; i < WIN; i++) cycle(1, 1, 1, 0, 1, "win_zero");
        cycle(0, 0, 0, 0, 1, "consume_zero");

        // en toggles every cycle: 8 enabled +1 samples then 8 enabled zeros.
        for (int i = 0; i < 31; i++) begin
            if (i % 2 == 0) cycle(1, (i < 16), 0, 0, 0, "en_toggle");
            else            cycle(0, 1, 0, 0, 0, "en_toggle");
        end
        cycle(0, 0, 0, 0, 1, "consume_toggle");

        // Result left unconsumed across two windows: second overwrites first.
        for (int i = 0; i < WIN; i++) cycle(1, 1, 0, 0, 0, "hold_plus");
        for (int i = 0; i < WIN; i++) cycle(1, 0, 1, 0, 0, "hold_minus");
        cycle(0, 0, 0, 0, 1, "consume_hold");

        for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 0, "pre_clr");
        cycle(0, 1, 0, 1, 0, "clr_pulse");
        for (int i = 0; i < WIN; i++) cycle(1, 0, 1, 0, 0, "post_clr");
        cycle(0, 0, 0, 0, 1, "consume_clr");

        for (int i = 0; i < WIN - 1; i++) cycle(1, 1, 0, 0, 1, "clr_last_pre");
        cycle(1, 1, 0, 1, 1, "clr_on_last");
        cycle(0, 0, 0, 0, 1, "after_clr_last");

        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0, "pre_reset");
        do_reset("mid_reset");
        for (int i = 0; i < WIN; i++) cycle(1, 1, 0, 0, 0, "fresh_window");
        cycle(0, 0, 0, 0, 1, "consume_fresh");

        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 60) == 0), ($urandom_range(0, 2) == 0), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
